// File: rtl/multi_sel_sched_pkg.sv
// Shared types and constants for the multi-select scheduler: FSM states,
// phase encodings and the shift amounts used to form the x3/x7/x8 beats.
package multi_sel_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [1:0] PH_X1 = 2'd0;
    localparam logic [1:0] PH_X3 = 2'd1;
    localparam logic [1:0] PH_X7 = 2'd2;
    localparam logic [1:0] PH_X8 = 2'd3;

    // x3 = (d<<1)+d, x7 = (d<<3)-d, x8 = d<<3
    localparam int unsigned SH_X3 = 1;
    localparam int unsigned SH_X7 = 3;
    localparam int unsigned SH_X8 = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr_i,
// wrapping from NREQ-1 back to 0. Purely combinational.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  gnt_idx_o
);

    int unsigned idx;
    logic [IDW-1:0] sel;
    logic found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = 0;
        sel       = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 32'(ptr_i) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            sel = IDW'(idx);
            if (en_i && !found && req_i[sel]) begin
                found     = 1'b1;
                gnt_o[sel] = 1'b1;
                gnt_idx_o = sel;
            end
        end
    end

endmodule

// File: rtl/multi_sel_sched.sv
// Round-robin scheduler feeding one shift-add datapath: each granted operand
// is emitted as four beats d*1, d*3, d*7, d*8 tagged with requester id and phase.
module multi_sel_sched
    import multi_sel_sched_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 8,
    localparam int unsigned OW  = DW + 3,
    localparam int unsigned IDW = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid_i,
    input  logic [NREQ*DW-1:0] req_data_i,
    output logic [NREQ-1:0]    req_ready_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [OW-1:0]      out_data_o,
    output logic [IDW-1:0]     out_id_o,
    output logic [1:0]         out_phase_o,
    output logic               out_last_o
);

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [DW-1:0]   opd_q, opd_d;
    logic            out_valid_q, out_valid_d;
    logic [OW-1:0]   out_data_q, out_data_d;
    logic [IDW-1:0]  out_id_q, out_id_d;
    logic [1:0]      out_phase_q, out_phase_d;

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic            xfer, last_xfer, win;
    logic [DW-1:0]   sel_opd;
    logic [OW-1:0]   opd_ext;
    logic [1:0]      nxt_phase;

    assign xfer      = out_valid_q && out_ready_i;
    assign last_xfer = xfer && (out_phase_q == PH_X8);
    assign win       = (state_q == IDLE) || ((state_q == RUN) && last_xfer);
    assign opd_ext   = OW'(opd_q);
    assign nxt_phase = out_phase_q + 2'd1;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i     (req_valid_i),
        .ptr_i     (ptr_q),
        .en_i      (win),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    // Operand mux driven by the one-hot grant
    always_comb begin
        sel_opd = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_opd = req_data_i[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        opd_d       = opd_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        out_phase_d = out_phase_q;

        if (win && (|gnt)) begin
            state_d     = RUN;
            opd_d       = sel_opd;
            out_id_d    = gnt_idx;
            ptr_d       = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
            out_valid_d = 1'b1;
            out_phase_d = PH_X1;
            out_data_d  = OW'(sel_opd);
        end else if ((state_q == RUN) && last_xfer) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else if ((state_q == RUN) && xfer) begin
            out_phase_d = nxt_phase;
            case (nxt_phase)
                PH_X3:   out_data_d = (opd_ext << SH_X3) + opd_ext;
                PH_X7:   out_data_d = (opd_ext << SH_X7) - opd_ext;
                PH_X8:   out_data_d = opd_ext << SH_X8;
                default: out_data_d = opd_ext;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            opd_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            out_phase_q <= PH_X1;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            opd_q       <= opd_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            out_phase_q <= out_phase_d;
        end
    end

    assign req_ready_o = gnt;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_id_o    = out_id_q;
    assign out_phase_o = out_phase_q;
    assign out_last_o  = out_valid_q && (out_phase_q == PH_X8);

endmodule
